key_sense: RTL
==============

KEY_SENSE -- requirements
Module: key_sense

Interface
REQ-001 Parameter NUM_KEYS, default 8: number of capacitive pads scanned.
REQ-002 Parameter DISCHARGE_CYCLES, default 64: clocks each pad is held low before measurement.
REQ-003 Parameter TIMEOUT, default 4095: measurement count ceiling, 12-bit.
REQ-004 Parameter THRESH_ON, default 200: count at or above which a sample reads pressed.
REQ-005 Parameter THRESH_OFF, default 150: count below which a sample reads released.
REQ-006 Parameter DEBOUNCE, default 3: consecutive disagreeing samples needed to change a key.
REQ-007 clk  input  1  system clock; one clock, all state on rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-low.
REQ-009 pad_in  input  NUM_KEYS  raw pad levels, asynchronous to clk.
REQ-010 pad_dis  output  NUM_KEYS  1 = drive pad low (discharge), 0 = release to external charge resistor.
REQ-011 keys  output  NUM_KEYS  debounced pressed state, 1 = pressed; feeds the display stage.
REQ-012 fault  output  NUM_KEYS  1 = last measurement of that pad hit TIMEOUT.
REQ-013 scan_done  output  1  one-cycle pulse after the last key of a round is evaluated.
REQ-014 cur_key  output  4  index of the key currently being scanned (debug digit).
REQ-015 cur_count  output  12  live measurement counter (debug digits).

Function
REQ-016 pad_in SHALL pass through a 2-flop synchronizer per bit; all decisions use the synchronized value.
REQ-017 FSM states SHALL be DISCHARGE, MEASURE, EVAL; keys are scanned in order 0..NUM_KEYS-1, then wrap to 0.
REQ-018 DISCHARGE: pad_dis[cur_key]=1 for exactly DISCHARGE_CYCLES clocks, cur_count held 0, then MEASURE.
REQ-019 MEASURE: pad_dis[cur_key]=0; cur_count starts at 0 on the first MEASURE cycle and increments by 1 each clock the synchronized pad_in[cur_key] is 0.
REQ-020 MEASURE SHALL exit to EVAL on the first clock synchronized pad_in[cur_key] is 1 (count not incremented that clock) or when cur_count equals TIMEOUT (saturates, no wrap).
REQ-021 Pads other than cur_key SHALL have pad_dis=1 at all times.
REQ-022 EVAL lasts exactly one clock; sample = pressed if count>=THRESH_ON, released if count<THRESH_OFF, otherwise equal to current keys[k] (hysteresis band).
REQ-023 Timeout: fault[k]=1 and keys[k] and its debounce counter SHALL be left unchanged; a non-timeout EVAL clears fault[k].
REQ-024 Debounce: per-key counter; sample != keys[k] increments it, sample == keys[k] clears it; on reaching DEBOUNCE keys[k] toggles and counter clears in the same EVAL.
REQ-025 After EVAL of key NUM_KEYS-1, scan_done SHALL be 1 for the following clock only, concurrent with DISCHARGE of key 0.
REQ-026 cur_key SHALL update on the EVAL->DISCHARGE transition; keys/fault change only at EVAL.
REQ-027 pad_in changes outside MEASURE of the addressed pad SHALL have no effect.

Reset
REQ-028 On rst low, immediately: state DISCHARGE, cur_key 0, cur_count 0, pad_dis all 1, keys 0, fault 0, scan_done 0, debounce counters 0, synchronizers 0.
REQ-029 Reset asserted mid-MEASURE SHALL abandon the measurement with no keys/fault update; release restarts at key 0 DISCHARGE.
REQ-030 First rising edge after rst deasserts SHALL count as DISCHARGE cycle 1 of key 0.

Verification
REQ-031 Pad 2 rises 300 clocks after release on 3 consecutive rounds, others at 50 -> keys[2]=1 after 3rd round EVAL, keys else 0, scan_done once per round.
REQ-032 Pad 2 then at 170 (band) for 5 rounds -> keys[2] stays 1; then at 100 for 3 rounds -> keys[2]=0 exactly at 3rd EVAL.
REQ-033 Pad 5 at 300 for 2 rounds then 50 once, then 300 for 2 -> keys[5] stays 0 (counter cleared).
REQ-034 Pad 7 never rises -> cur_count saturates at 4095, fault[7]=1, keys[7] unchanged; pad returns at 50 -> fault[7]=0 next round.
REQ-035 Reset pulsed while cur_key=4 in MEASURE -> all outputs at reset values asynchronously, next scan begins key 0 with 64 discharge cycles.
REQ-036 Check every cycle: at most one pad_dis bit is 0, and only in MEASURE.

Source files
------------

// File: rtl/key_sense.sv
// Capacitive key scanner: discharges each pad in turn, times how long it takes
// to recharge, and debounces the thresholded result into a per-key pressed state.
module key_sense #(
    parameter int NUM_KEYS         = 8,
    parameter int DISCHARGE_CYCLES = 64,
    parameter int TIMEOUT          = 4095,
    parameter int THRESH_ON        = 200,
    parameter int THRESH_OFF       = 150,
    parameter int DEBOUNCE         = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] pad_in,
    output logic [NUM_KEYS-1:0] pad_dis,
    output logic [NUM_KEYS-1:0] keys,
    output logic [NUM_KEYS-1:0] fault,
    output logic                scan_done,
    output logic [3:0]          cur_key,
    output logic [11:0]         cur_count
);
    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int DW = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;
    localparam int CW = $clog2(DEBOUNCE + 1);

    localparam logic [11:0]   CNT_MAX  = 12'(TIMEOUT);
    localparam logic [11:0]   CNT_ON   = 12'(THRESH_ON);
    localparam logic [11:0]   CNT_OFF  = 12'(THRESH_OFF);
    localparam logic [DW-1:0] DIS_LAST = DW'(DISCHARGE_CYCLES - 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE - 1);
    localparam logic [3:0]    KEY_LAST = 4'(NUM_KEYS - 1);

    typedef enum logic [1:0] {
        S_DISCHARGE,
        S_MEASURE,
        S_EVAL
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] r_keys;
    logic [NUM_KEYS-1:0] r_fault;
    logic [DW-1:0]       r_disCnt;
    logic [11:0]         r_count;
    logic [3:0]          r_key;
    logic [CW-1:0]       r_deb [NUM_KEYS];
    logic                r_scanDone;

    logic [KW-1:0]       w_idx;
    logic                w_padNow;
    logic                w_atMax;
    logic                w_sample;

    assign w_idx    = r_key[KW-1:0];
    assign w_padNow = r_sync2[w_idx];
    assign w_atMax  = (r_count == CNT_MAX);

    // Counts inside the hysteresis band keep the key's present state.
    always_comb begin
        if (r_count >= CNT_ON) begin
            w_sample = 1'b1;
        end else if (r_count < CNT_OFF) begin
            w_sample = 1'b0;
        end else begin
            w_sample = r_keys[w_idx];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_DISCHARGE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Saturation is checked first, so a count parked at the ceiling in EVAL
    // always means the measurement timed out.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_DISCHARGE: begin
                if (r_disCnt == DIS_LAST) begin
                    w_nextState = S_MEASURE;
                end
            end
            S_MEASURE: begin
                if (w_atMax || w_padNow) begin
                    w_nextState = S_EVAL;
                end
            end
            S_EVAL: begin
                w_nextState = S_DISCHARGE;
            end
            default: begin
                w_nextState = S_DISCHARGE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1    <= '0;
            r_sync2    <= '0;
            r_keys     <= '0;
            r_fault    <= '0;
            r_disCnt   <= '0;
            r_count    <= '0;
            r_key      <= '0;
            r_scanDone <= 1'b0;
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_deb[i] <= '0;
            end
        end else begin
            r_sync1    <= pad_in;
            r_sync2    <= r_sync1;
            r_scanDone <= 1'b0;
            case (r_state)
                S_DISCHARGE: begin
                    r_count  <= '0;
                    r_disCnt <= (r_disCnt == DIS_LAST) ? '0 : r_disCnt + DW'(1);
                end
                S_MEASURE: begin
                    if (!w_atMax && !w_padNow) begin
                        r_count <= r_count + 12'd1;
                    end
                end
                S_EVAL: begin
                    if (w_atMax) begin
                        r_fault[w_idx] <= 1'b1;
                    end else begin
                        r_fault[w_idx] <= 1'b0;
                        if (w_sample == r_keys[w_idx]) begin
                            r_deb[w_idx] <= '0;
                        end else if (r_deb[w_idx] == DEB_LAST) begin
                            r_keys[w_idx] <= ~r_keys[w_idx];
                            r_deb[w_idx]  <= '0;
                        end else begin
                            r_deb[w_idx] <= r_deb[w_idx] + CW'(1);
                        end
                    end
                    r_count    <= '0;
                    r_scanDone <= (r_key == KEY_LAST);
                    r_key      <= (r_key == KEY_LAST) ? 4'd0 : r_key + 4'd1;
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    // Every pad except the one being timed is held discharged.
    always_comb begin
        pad_dis = '1;
        if (r_state == S_MEASURE) begin
            pad_dis[w_idx] = 1'b0;
        end
    end

    assign keys      = r_keys;
    assign fault     = r_fault;
    assign scan_done = r_scanDone;
    assign cur_key   = r_key;
    assign cur_count = r_count;

endmodule
